clint_responder: RTL and testbench

CLINT_RESPONDER -- requirements
Module: clint_responder

---
 rtl/clint_responder.sv | 152 +++++++++++++++
 tb/tb_clint_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/clint_responder.sv
// -----------------------------------------------------------------------------
// clint_responder
//   Core-local interruptor (CLINT) register responder for a single hart.
//   Exposes msip, mtimecmp and mtime behind a simple valid/ready request /
//   response bus with one-cycle response latency, and generates the machine
//   timer and software interrupt levels.
//
//   Parameters
//     BASE      base byte address of the register window
//     TICK_DIV  clock cycles per mtime increment (1..65535)
//
//   Ports
//     clock       rising-edge clock for all state
//     reset       asynchronous active-high reset
//     req_valid   request present            req_ready   request accepted (IDLE)
//     req_wen     1 = write, 0 = read        req_addr    byte address
//     req_wdata   write data                 req_wmask   per-bit write mask
//     resp_valid  response present (RESP)    resp_ready  initiator takes response
//     resp_rdata  read data (0 for writes / errors)
//     resp_err    unmapped or misaligned access
//     timer_irq   registered (mtime >= mtimecmp)
//     soft_irq    msip bit 0
// -----------------------------------------------------------------------------
module clint_responder #(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [63:0] req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam logic [63:0] ADDR_MSIP     = BASE;
  localparam logic [63:0] ADDR_MTIMECMP = BASE + 64'h4000;
  localparam logic [63:0] ADDR_MTIME    = BASE + 64'hBFF8;
  localparam logic [15:0] PRESC_MAX     = 16'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        timer_irq_q, timer_irq_d;

  logic        aligned;
  logic        hit_msip, hit_cmp, hit_time, hit_any;
  logic        tick;

  // Masked read-modify-write merge shared by all writable registers.
  function automatic logic [63:0] wmerge(input logic [63:0] old_v,
                                         input logic [63:0] wdata,
                                         input logic [63:0] wmask);
    return (old_v & ~wmask) | (wdata & wmask);
  endfunction

  always_comb begin
    aligned  = (req_addr[2:0] == 3'b000);
    hit_msip = aligned && (req_addr == ADDR_MSIP);
    hit_cmp  = aligned && (req_addr == ADDR_MTIMECMP);
    hit_time = aligned && (req_addr == ADDR_MTIME);
    hit_any  = hit_msip || hit_cmp || hit_time;

    // The prescaler free-runs independent of bus traffic; with TICK_DIV=1
    // it sits at 0 and every cycle is a tick.
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? 16'd0 : presc_q + 16'd1;

    state_d      = state_q;
    mtime_d      = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d   = mtimecmp_q;
    msip_d       = msip_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    if (state_q == S_IDLE) begin
      if (req_valid) begin
        state_d      = S_RESP;
        resp_err_d   = !hit_any;
        resp_rdata_d = 64'd0;
        if (!req_wen) begin
          // Read data is the pre-edge register value, not the incremented one.
          if (hit_msip)      resp_rdata_d = {63'd0, msip_q};
          else if (hit_cmp)  resp_rdata_d = mtimecmp_q;
          else if (hit_time) resp_rdata_d = mtime_q;
        end else begin
          if (hit_msip)
            msip_d = (msip_q & ~req_wmask[0]) | (req_wdata[0] & req_wmask[0]);
          if (hit_cmp)
            mtimecmp_d = wmerge(mtimecmp_q, req_wdata, req_wmask);
          // A bus write to mtime overrides the same-edge increment.
          if (hit_time)
            mtime_d = wmerge(mtime_q, req_wdata, req_wmask);
        end
      end
    end else begin
      if (resp_ready) begin
        state_d      = S_IDLE;
        resp_rdata_d = 64'd0;
        resp_err_d   = 1'b0;
      end
    end

    // Compares the current register contents, so the interrupt follows the
    // condition by one cycle.
    timer_irq_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      presc_q      <= 16'd0;
      mtime_q      <= 64'd0;
      mtimecmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q       <= 1'b0;
      resp_rdata_q <= 64'd0;
      resp_err_q   <= 1'b0;
      timer_irq_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      timer_irq_q  <= timer_irq_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign timer_irq  = timer_irq_q;
  assign soft_irq   = msip_q;

endmodule

// File: tb/tb_clint_responder.sv
module tb_clint_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] req_wmask;
  logic        resp_ready;

  logic        req_ready, resp_valid, resp_err, timer_irq, soft_irq;
  logic [63:0] resp_rdata;
  logic        req_ready4, resp_valid4, resp_err4, timer_irq4, soft_irq4;
  logic [63:0] resp_rdata4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] rd, rd4, r_a, r_b, r4_a, r4_b;
  logic        er;

  clint_responder #(.BASE(BASE), .TICK_DIV(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .timer_irq(timer_irq), .soft_irq(soft_irq)
  );

  clint_responder #(.BASE(BASE), .TICK_DIV(4)) dut4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready4), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid4), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata4), .resp_err(resp_err4),
    .timer_irq(timer_irq4), .soft_irq(soft_irq4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Call #1 after a rising edge with the DUT idle: accept on the next edge,
  // sample the response at the following falling edge, complete handshake.
  task automatic bus_op(input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] wmask,
                        output logic [63:0] rdata, output logic err);
    check("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wdata; req_wmask = wmask;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    check("resp_valid_lat1", {63'd0, resp_valid}, 64'd1);
    rdata = resp_rdata;
    err   = resp_err;
    rd4   = resp_rdata4;
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 64'd0;
    req_wdata = 64'd0; req_wmask = 64'd0; resp_ready = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready",  {63'd0, req_ready},  64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata,          64'd0);
    check("rst_resp_err",   {63'd0, resp_err},   64'd0);
    check("rst_timer_irq",  {63'd0, timer_irq},  64'd0);
    check("rst_soft_irq",   {63'd0, soft_irq},   64'd0);

    // Release just after edge R0; edges R1.. each increment mtime (TICK_DIV=1).
    @(posedge clock); #1 reset = 1'b0;
    repeat (9) @(posedge clock); #1;
    bus_op(1'b0, A_TIME, 64'd0, 64'd0, rd, er);       // accepted at R10
    check("mtime_at_r10",  rd, 64'd9);
    check("mtime_err",     {63'd0, er}, 64'd0);
    check("mtime4_at_r10", rd4, 64'd2);

    // Timer compare: mtimecmp=20 written at R12, mtime==20 after R20.
    bus_op(1'b1, A_CMP, 64'd20, ONES, rd, er);
    check("wr_rdata_zero", rd, 64'd0);
    repeat (7) @(posedge clock);                      // R20
    @(negedge clock);
    check("tirq_not_yet", {63'd0, timer_irq}, 64'd0);
    @(posedge clock);                                 // R21
    @(negedge clock);
    check("tirq_set", {63'd0, timer_irq}, 64'd1);
    @(posedge clock); #1;
    bus_op(1'b1, A_CMP, ONES, ONES, rd, er);
    check("tirq_clear", {63'd0, timer_irq}, 64'd0);

    // Software interrupt.
    bus_op(1'b1, A_MSIP, 64'hFF, 64'h1, rd, er);
    check("sirq_set", {63'd0, soft_irq}, 64'd1);
    bus_op(1'b0, A_MSIP, 64'd0, 64'd0, rd, er);
    check("msip_read", rd, 64'h1);
    bus_op(1'b1, A_MSIP, 64'd0, ONES, rd, er);
    check("sirq_clear", {63'd0, soft_irq}, 64'd0);

    // Decode errors and masked writes.
    bus_op(1'b0, BASE + 64'h8, 64'd0, 64'd0, rd, er);
    check("err_b8_flag",  {63'd0, er}, 64'd1);
    check("err_b8_rdata", rd, 64'd0);
    bus_op(1'b0, BASE + 64'h4004, 64'd0, 64'd0, rd, er);
    check("err_4004_flag",  {63'd0, er}, 64'd1);
    check("err_4004_rdata", rd, 64'd0);
    bus_op(1'b1, BASE + 64'h4004, 64'd5, ONES, rd, er);
    check("err_wr_flag", {63'd0, er}, 64'd1);
    bus_op(1'b1, BASE + 64'h8, 64'd1, ONES, rd, er);
    check("err_wr_msip_kept", {63'd0, soft_irq}, 64'd0);
    bus_op(1'b0, A_CMP, 64'd0, 64'd0, rd, er);
    check("cmp_unchanged", rd, ONES);
    check("cmp_read_err",  {63'd0, er}, 64'd0);
    bus_op(1'b1, A_CMP, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_FFFF_0000, rd, er);
    bus_op(1'b0, A_CMP, 64'd0, 64'd0, rd, er);
    check("cmp_masked_wr", rd, 64'hFFFF_FFFF_9ABC_FFFF);
    bus_op(1'b1, A_CMP, ONES, ONES, rd, er);

    // mtime wrap: written at edge E, read accepted at E+2 then E+3.
    bus_op(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, ONES, rd, er);
    bus_op(1'b0, A_TIME, 64'd0, 64'd0, rd, er);
    check("mtime_max", rd, ONES);
    bus_op(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, ONES, rd, er);
    @(posedge clock); #1;
    bus_op(1'b0, A_TIME, 64'd0, 64'd0, rd, er);
    check("mtime_wrapped", rd, 64'd0);

    // Two reads accepted exactly 8 edges apart.
    bus_op(1'b0, A_TIME, 64'd0, 64'd0, r_a, er);
    r4_a = rd4;
    repeat (6) @(posedge clock); #1;
    bus_op(1'b0, A_TIME, 64'd0, 64'd0, r_b, er);
    r4_b = rd4;
    check("div1_8cyc", r_b - r_a, 64'd8);
    check("div4_8cyc", r4_b - r4_a, 64'd2);

    // Back-pressure: response held while req_valid stays high.
    bus_op(1'b1, A_MSIP, 64'd1, 64'd1, rd, er);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = A_CMP;
    @(posedge clock);
    #1 req_addr = A_MSIP;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_resp_rdata", resp_rdata, ONES);
      check("hold_req_ready",  {63'd0, req_ready}, 64'd0);
      @(posedge clock);
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    check("hs_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("hs_req_ready",  {63'd0, req_ready},  64'd1);
    @(posedge clock);
    @(negedge clock);
    check("second_resp_valid", {63'd0, resp_valid}, 64'd1);
    check("second_resp_rdata", resp_rdata, 64'h1);

    // Reset while in RESP.
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("mid_rst_req_ready",  {63'd0, req_ready},  64'd1);
    check("mid_rst_rdata",      resp_rdata,          64'd0);
    check("mid_rst_err",        {63'd0, resp_err},   64'd0);
    check("mid_rst_timer_irq",  {63'd0, timer_irq},  64'd0);
    check("mid_rst_soft_irq",   {63'd0, soft_irq},   64'd0);
    @(posedge clock); #1 reset = 1'b0;
    bus_op(1'b0, A_TIME, 64'd0, 64'd0, rd, er);
    check("post_rst_mtime", rd, 64'd0);
    bus_op(1'b0, A_CMP, 64'd0, 64'd0, rd, er);
    check("post_rst_cmp", rd, ONES);
    bus_op(1'b0, A_MSIP, 64'd0, 64'd0, rd, er);
    check("post_rst_msip", rd, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
